lapido_exec_ctrl: RTL and testbench

- Multicycle execute sequencer for the Lapido datapath.
- Accepts one decoded instruction per valid/ready handshake and issues ALU operations with the same 5-bit op encoding the flags register uses.
- Waits for ALU completion, then commits ALU flags into an internal flags register under a per-op update mask and pulses register writeback.
- Also evaluates conditional branches against the committed flags.

---
 rtl/lapido_exec_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_lapido_exec_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lapido_exec_ctrl.sv
// Multicycle execute sequencer: issues ALU ops, commits masked flags, evaluates branches.
// Optional ALU wait timeout is enabled by defining ALU_TIMEOUT_EN.
module lapido_exec_ctrl #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned TO_W    = 5
) (
  input  logic       clk,
  input  logic       r,
  input  logic       instr_valid,
  output logic       instr_ready,
  input  logic [1:0] instr_kind,
  input  logic [4:0] alu_op,
  input  logic [2:0] br_cond,
  output logic       alu_start,
  output logic [4:0] alu_cond,
  input  logic       alu_done,
  input  logic [3:0] alu_flags,
  output logic [3:0] flags,
  output logic       reg_we,
  output logic       br_taken,
  output logic       done,
  output logic       illegal,
  output logic       timeout
);

  localparam int unsigned OP_W = 5;
  localparam int unsigned FL_W = 4;
  localparam int unsigned CC_W = 3;

  localparam logic [1:0] KIND_ALU  = 2'b00;
  localparam logic [1:0] KIND_BR   = 2'b01;
  localparam logic [1:0] KIND_JMP  = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ISSUE  = 3'd1,
    S_WAIT   = 3'd2,
    S_COMMIT = 3'd3,
    S_EVAL   = 3'd4
  } state_e;

  if (TO_W < 1 || (64'(1) << TO_W) <= 64'(TIMEOUT)) begin : g_bad_cfg
    $error("lapido_exec_ctrl: TO_W too narrow for TIMEOUT");
  end

  // Flag update mask {o,s,c,z}; an all-zero mask marks an unsupported op.
  function automatic logic [FL_W-1:0] op_mask(input logic [OP_W-1:0] op);
    logic [FL_W-1:0] m;
    m = '0;
    case (op)
      5'b00000, 5'b00001, 5'b00011, 5'b00100,
      5'b00101, 5'b00110, 5'b01001:            m = 4'b1111;
      5'b01000:                                m = 4'b0111;
      5'b10000:                                m = 4'b0001;
      5'b10001, 5'b01010, 5'b01011,
      5'b10100, 5'b10101, 5'b10110, 5'b10111,
      5'b11000, 5'b11001, 5'b11010, 5'b11011,
      5'b11100, 5'b11101, 5'b11110:            m = 4'b0101;
      default:                                 m = 4'b0000;
    endcase
    return m;
  endfunction

  // cond[2:1] picks the flag bit, cond[0] inverts it.
  function automatic logic cond_met(input logic [CC_W-1:0] c, input logic [FL_W-1:0] f);
    return f[c[2:1]] ^ c[0];
  endfunction

  state_e          state_q, state_d;
  logic [FL_W-1:0] flags_q, flags_d;
  logic [OP_W-1:0] alu_cond_q, alu_cond_d;
  logic            ready_q, ready_d;
  logic            start_q, start_d;
  logic            reg_we_q, reg_we_d;
  logic            br_q, br_d;
  logic            done_q, done_d;
  logic            illegal_q, illegal_d;
  logic [FL_W-1:0] accept_mask;
  logic [FL_W-1:0] commit_mask;
  logic            accept;

`ifdef ALU_TIMEOUT_EN
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic            timeout_q, timeout_d;
`endif

  assign accept      = instr_valid && ready_q;
  assign accept_mask = op_mask(alu_op);
  assign commit_mask = op_mask(alu_cond_q);

  always_comb begin
    state_d    = state_q;
    flags_d    = flags_q;
    alu_cond_d = alu_cond_q;
    start_d    = 1'b0;
    reg_we_d   = 1'b0;
    br_d       = 1'b0;
    done_d     = 1'b0;
    illegal_d  = illegal_q;
`ifdef ALU_TIMEOUT_EN
    cnt_d      = cnt_q;
    timeout_d  = timeout_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (instr_kind)
            KIND_ALU: begin
              if (accept_mask != '0) begin
                alu_cond_d = alu_op;
                start_d    = 1'b1;
                state_d    = S_ISSUE;
              end else begin
                illegal_d = 1'b1;
                done_d    = 1'b1;
              end
            end
            KIND_BR: begin
              br_d    = cond_met(br_cond, flags_q);
              done_d  = 1'b1;
              state_d = S_EVAL;
            end
            KIND_JMP: begin
              br_d    = 1'b1;
              done_d  = 1'b1;
              state_d = S_EVAL;
            end
            default: done_d = 1'b1;
          endcase
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
`ifdef ALU_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      S_WAIT: begin
        // alu_done wins over a same-cycle timeout.
        if (alu_done) begin
          flags_d  = (flags_q & ~commit_mask) | (alu_flags & commit_mask);
          reg_we_d = 1'b1;
          done_d   = 1'b1;
          state_d  = S_COMMIT;
        end
`ifdef ALU_TIMEOUT_EN
        else if (cnt_q + TO_W'(1) == TO_W'(TIMEOUT)) begin
          timeout_d = 1'b1;
          done_d    = 1'b1;
          state_d   = S_IDLE;
        end else begin
          cnt_d = cnt_q + TO_W'(1);
        end
`endif
      end
      S_COMMIT: state_d = S_IDLE;
      S_EVAL:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk or posedge r) begin
    if (r) begin
      state_q    <= S_IDLE;
      flags_q    <= '0;
      alu_cond_q <= '0;
      ready_q    <= 1'b1;
      start_q    <= 1'b0;
      reg_we_q   <= 1'b0;
      br_q       <= 1'b0;
      done_q     <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      flags_q    <= flags_d;
      alu_cond_q <= alu_cond_d;
      ready_q    <= ready_d;
      start_q    <= start_d;
      reg_we_q   <= reg_we_d;
      br_q       <= br_d;
      done_q     <= done_d;
      illegal_q  <= illegal_d;
    end
  end

`ifdef ALU_TIMEOUT_EN
  always_ff @(posedge clk or posedge r) begin
    if (r) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  assign instr_ready = ready_q;
  assign alu_start   = start_q;
  assign alu_cond    = alu_cond_q;
  assign flags       = flags_q;
  assign reg_we      = reg_we_q;
  assign br_taken    = br_q;
  assign done        = done_q;
  assign illegal     = illegal_q;

endmodule

// File: tb/tb_lapido_exec_ctrl.sv
// Directed bench for lapido_exec_ctrl: ALU commit, flag masks, branches, illegal ops, reset, timeout.
module tb_lapido_exec_ctrl;

  logic       clk = 1'b0;
  logic       r;
  logic       instr_valid;
  logic       instr_ready;
  logic [1:0] instr_kind;
  logic [4:0] alu_op;
  logic [2:0] br_cond;
  logic       alu_start;
  logic [4:0] alu_cond;
  logic       alu_done;
  logic [3:0] alu_flags;
  logic [3:0] flags;
  logic       reg_we;
  logic       br_taken;
  logic       done;
  logic       illegal;
  logic       timeout;

  int vectors = 0;
  int miscompares = 0;

  lapido_exec_ctrl #(.TIMEOUT(16), .TO_W(5)) dut (
    .clk         (clk),
    .r           (r),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr_kind  (instr_kind),
    .alu_op      (alu_op),
    .br_cond     (br_cond),
    .alu_start   (alu_start),
    .alu_cond    (alu_cond),
    .alu_done    (alu_done),
    .alu_flags   (alu_flags),
    .flags       (flags),
    .reg_we      (reg_we),
    .br_taken    (br_taken),
    .done        (done),
    .illegal     (illegal),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Offer one instruction in an IDLE cycle; returns in the cycle after acceptance.
  task automatic send(input logic [1:0] k, input logic [4:0] op, input logic [2:0] c);
    instr_valid = 1'b1;
    instr_kind  = k;
    alu_op      = op;
    br_cond     = c;
    step();
    instr_valid = 1'b0;
  endtask

  // ALU op with alu_done raised in WAIT cycle nwait (nwait >= 1); ends in the IDLE cycle after COMMIT.
  task automatic run_alu(input string tag, input logic [4:0] op, input logic [3:0] af,
                         input int nwait, input logic [3:0] exp_flags);
    int starts;
    send(2'b00, op, 3'b000);
    starts = int'(alu_start);
    chk({tag, "_cond_issue"}, 8'(alu_cond), 8'(op));
    repeat (nwait) begin
      step();
      starts += int'(alu_start);
    end
    alu_done  = 1'b1;
    alu_flags = af;
    step();
    alu_done  = 1'b0;
    chk({tag, "_we"}, 8'(reg_we), 8'h1);
    chk({tag, "_done"}, 8'(done), 8'h1);
    chk({tag, "_starts"}, 8'(starts), 8'h1);
    chk({tag, "_cond_commit"}, 8'(alu_cond), 8'(op));
    step();
    chk({tag, "_flags"}, 8'(flags), 8'(exp_flags));
    chk({tag, "_we_drop"}, 8'(reg_we), 8'h0);
    chk({tag, "_ready"}, 8'(instr_ready), 8'h1);
  endtask

  initial begin
    r           = 1'b1;
    instr_valid = 1'b0;
    instr_kind  = 2'b00;
    alu_op      = 5'b00000;
    br_cond     = 3'b000;
    alu_done    = 1'b0;
    alu_flags   = 4'b0000;
    step();
    step();
    chk("rst_ready", 8'(instr_ready), 8'h1);
    chk("rst_flags", 8'(flags), 8'h0);
    chk("rst_cond", 8'(alu_cond), 8'h0);
    chk("rst_done", 8'(done), 8'h0);
    chk("rst_illegal", 8'(illegal), 8'h0);
    chk("rst_timeout", 8'(timeout), 8'h0);
    r = 1'b0;
    step();

    // add, then masked xor (0101) and lsl (0111)
    run_alu("add", 5'b00000, 4'b1011, 3, 4'b1011);
    run_alu("xor", 5'b10110, 4'b0100, 1, 4'b1110);
    run_alu("lsl", 5'b01000, 4'b0001, 2, 4'b1001);

    // branches against flags = 0010
    run_alu("setc", 5'b00000, 4'b0010, 1, 4'b0010);
    send(2'b01, 5'b00000, 3'b010);
    chk("br_c_taken", 8'(br_taken), 8'h1);
    chk("br_c_done", 8'(done), 8'h1);
    step();
    chk("br_c_pulse", 8'(br_taken), 8'h0);
    send(2'b01, 5'b00000, 3'b000);
    chk("br_z_taken", 8'(br_taken), 8'h0);
    chk("br_z_done", 8'(done), 8'h1);
    step();
    send(2'b01, 5'b00000, 3'b011);
    chk("br_nc_taken", 8'(br_taken), 8'h0);
    step();
    send(2'b01, 5'b00000, 3'b001);
    chk("br_nz_taken", 8'(br_taken), 8'h1);
    step();
    send(2'b10, 5'b00000, 3'b000);
    chk("jmp_taken", 8'(br_taken), 8'h1);
    chk("jmp_done", 8'(done), 8'h1);
    step();

    // illegal op, then a legal op still runs
    send(2'b00, 5'b11111, 3'b000);
    chk("ill_start", 8'(alu_start), 8'h0);
    chk("ill_flag", 8'(illegal), 8'h1);
    chk("ill_done", 8'(done), 8'h1);
    chk("ill_ready", 8'(instr_ready), 8'h1);
    chk("ill_flags", 8'(flags), 8'h2);
    step();
    chk("ill_done_drop", 8'(done), 8'h0);
    chk("ill_sticky", 8'(illegal), 8'h1);
    run_alu("post_ill", 5'b00001, 4'b1100, 1, 4'b1100);
    chk("ill_sticky2", 8'(illegal), 8'h1);

    // nop
    send(2'b11, 5'b00000, 3'b000);
    chk("nop_done", 8'(done), 8'h1);
    chk("nop_ready", 8'(instr_ready), 8'h1);
    step();

    // alu_done outside WAIT is ignored
    alu_done  = 1'b1;
    alu_flags = 4'b0011;
    step();
    chk("idle_done_ign", 8'(done), 8'h0);
    chk("idle_we_ign", 8'(reg_we), 8'h0);
    alu_done = 1'b0;
    send(2'b00, 5'b10000, 3'b000);
    alu_done  = 1'b1;
    alu_flags = 4'b0001;
    step();
    alu_done = 1'b0;
    chk("issue_done_ign", 8'(done), 8'h0);
    chk("issue_we_ign", 8'(reg_we), 8'h0);
    step();
    chk("wait_hold", 8'(instr_ready), 8'h0);
    alu_done  = 1'b1;
    alu_flags = 4'b1111;
    step();
    alu_done = 1'b0;
    chk("tst_we", 8'(reg_we), 8'h1);
    step();
    chk("tst_flags", 8'(flags), 8'hD);

    // branch accepted right after commit sees z=1
    send(2'b01, 5'b00000, 3'b000);
    chk("br_after_commit", 8'(br_taken), 8'h1);
    step();

`ifndef ALU_TIMEOUT_EN
    send(2'b00, 5'b00000, 3'b000);
    repeat (40) step();
    chk("nowait_ready", 8'(instr_ready), 8'h0);
    chk("nowait_timeout", 8'(timeout), 8'h0);
    alu_done  = 1'b1;
    alu_flags = 4'b0000;
    step();
    alu_done = 1'b0;
    chk("nowait_done", 8'(done), 8'h1);
    step();
`endif

    // reset asserted mid-WAIT
    send(2'b00, 5'b00000, 3'b000);
    step();
    #2;
    r = 1'b1;
    #1;
    chk("rw_flags", 8'(flags), 8'h0);
    chk("rw_ready", 8'(instr_ready), 8'h1);
    chk("rw_illegal", 8'(illegal), 8'h0);
    alu_done  = 1'b1;
    alu_flags = 4'b1111;
    step();
    chk("rw_done", 8'(done), 8'h0);
    chk("rw_we", 8'(reg_we), 8'h0);
    chk("rw_flags2", 8'(flags), 8'h0);
    alu_done = 1'b0;
    r        = 1'b0;
    step();
    chk("rw_ready2", 8'(instr_ready), 8'h1);

`ifdef ALU_TIMEOUT_EN
    run_alu("to16", 5'b00000, 4'b0110, 16, 4'b0110);
    chk("to16_timeout", 8'(timeout), 8'h0);
    send(2'b00, 5'b00000, 3'b000);
    repeat (16) step();
    chk("to_pre_done", 8'(done), 8'h0);
    chk("to_pre_ready", 8'(instr_ready), 8'h0);
    step();
    chk("to_done", 8'(done), 8'h1);
    chk("to_flag", 8'(timeout), 8'h1);
    chk("to_we", 8'(reg_we), 8'h0);
    chk("to_ready", 8'(instr_ready), 8'h1);
    step();
    chk("to_flags", 8'(flags), 8'h6);
    chk("to_sticky", 8'(timeout), 8'h1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
